floor_request_queue: RTL and testbench

FLOOR_REQUEST_QUEUE -- requirements
Module: floor_request_queue

---
 rtl/elevator_pkg.sv | 14 +
 rtl/floor_req_mem.sv | 36 +++
 rtl/floor_request_queue.sv | 107 ++++++++++
 tb/tb_floor_request_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor code width, default queue depth and floor codes.
// Pure definitions; no logic, no latency, no flow control.
// Imported by the floor request queue and its storage.
package elevator_pkg;

    localparam int FLOOR_W       = 2;
    localparam int DEPTH_DEFAULT = 4;

    localparam logic [FLOOR_W-1:0] FLOOR_0 = 2'd0;
    localparam logic [FLOOR_W-1:0] FLOOR_1 = 2'd1;
    localparam logic [FLOOR_W-1:0] FLOOR_2 = 2'd2;
    localparam logic [FLOOR_W-1:0] FLOOR_3 = 2'd3;

endpackage

// File: rtl/floor_req_mem.sv
// DEPTH x FLOOR_W register file, one write port, one registered read port.
// Latency: read data appears one edge after re; a same-edge write to raddr is forwarded.
// No backpressure: every write and read is accepted.
module floor_req_mem #(
    parameter int DEPTH   = 4,
    parameter int FLOOR_W = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [FLOOR_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [FLOOR_W-1:0] rdata
);

    logic [FLOOR_W-1:0] mem [DEPTH];

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/floor_request_queue.sv
// Circular queue of floor requests feeding the head floor to the comparator; DUP_FILTER_EN drops duplicates.
// Latency: push to an empty queue shows on pos0Mem/pos0Valid one edge later; pops update the head the same way.
// Backpressure: none upstream; pushes while full are dropped and latch the sticky overflow flag.
module floor_request_queue
    import elevator_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int FLOOR_W = elevator_pkg::FLOOR_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    input  logic               served,
    output logic [FLOOR_W-1:0] pos0Mem,
    output logic               pos0Valid,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count,
    output logic               overflow
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] count_nxt;
    logic          pop;
    logic          push;
    logic          dup;

`ifdef DUP_FILTER_EN
    // One presence bit per floor; the filter keeps at most one entry per floor.
    logic [(1<<FLOOR_W)-1:0] present;

    always_ff @(posedge clk) begin
        if (rst) begin
            present <= '0;
        end else begin
            if (pop) begin
                present[pos0Mem] <= 1'b0;
            end
            if (push) begin
                present[req_floor] <= 1'b1;
            end
        end
    end

    assign dup = present[req_floor];
`else
    assign dup = 1'b0;
`endif

    // Pop is resolved first so a full queue can accept a push in the same cycle.
    always_comb begin
        pop       = served && !empty;
        push      = req_valid && !dup && (!full || pop);
        rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            pos0Valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            full      <= (count_nxt == CW'(DEPTH));
            empty     <= (count_nxt == '0);
            pos0Valid <= (count_nxt != '0);
            if (req_valid && !dup && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head register only reloads while entries remain, so an emptied queue keeps the last popped floor.
    floor_req_mem #(
        .DEPTH   (DEPTH),
        .FLOOR_W (FLOOR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata (req_floor),
        .re    (count_nxt != '0),
        .raddr (rd_nxt),
        .rdata (pos0Mem)
    );

endmodule

// File: tb/tb_floor_request_queue.sv
// Self-checking bench for floor_request_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model; honours DUP_FILTER_EN.
module tb_floor_request_queue;
    import elevator_pkg::*;

    localparam int DEPTH = DEPTH_DEFAULT;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OW    = CW + FLOOR_W + 4;
`ifdef DUP_FILTER_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic [FLOOR_W-1:0] req_floor = '0;
    logic               served = 1'b0;
    logic [FLOOR_W-1:0] pos0Mem;
    logic               pos0Valid;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic               overflow;

    int vecs = 0;
    int errs = 0;

    logic [FLOOR_W-1:0] mq[$];
    bit                 m_ovf = 1'b0;
    logic [FLOOR_W-1:0] m_last = '0;

    floor_request_queue #(.DEPTH(DEPTH), .FLOOR_W(FLOOR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .served    (served),
        .pos0Mem   (pos0Mem),
        .pos0Valid (pos0Valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] obs = {count, full, empty, pos0Valid, pos0Mem, overflow};

    // Packs {count, full, empty, pos0Valid, pos0Mem, overflow}.
    function automatic logic [OW-1:0] pk(input int c, input bit f, input bit e,
                                         input bit pv, input int pm, input bit ov);
        return {CW'(c), f, e, pv, FLOOR_W'(pm), ov};
    endfunction

    function automatic logic [OW-1:0] model_exp();
        int n;
        n = mq.size();
        return pk(n, n == DEPTH, n == 0, n > 0, (n > 0) ? int'(mq[0]) : int'(m_last), m_ovf);
    endfunction

    task automatic model_step(input bit v, input logic [FLOOR_W-1:0] f, input bit s, input bit r);
        bit d;
        bit p;
        if (r) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_last = '0;
        end else begin
            d = 1'b0;
            if (DUP) foreach (mq[i]) if (mq[i] == f) d = 1'b1;
            p = s && (mq.size() > 0);
            if (p) m_last = mq.pop_front();
            if (v && !d) begin
                if (mq.size() < DEPTH) mq.push_back(f);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit v, input int f, input bit s, input bit r);
        req_valid = v;
        req_floor = FLOOR_W'(f);
        served    = s;
        rst       = r;
        @(posedge clk);
        model_step(v, FLOOR_W'(f), s, r);
        #1;
        req_valid = 1'b0;
        served    = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1, 2, 1, 1);
        vecs++;
        if (obs !== pk(0, 0, 1, 0, 0, 0)) begin
            errs++;
            $display("FAIL reset got=%b exp=%b", obs, pk(0, 0, 1, 0, 0, 0));
        end
    endtask

    task automatic test_push_pop();
        logic [OW-1:0] e [5];
        cycle(0, 0, 0, 1);
        e[0] = pk(1, 0, 0, 1, 3, 0);
        e[1] = pk(2, 0, 0, 1, 3, 0);
        e[2] = pk(1, 0, 0, 1, 1, 0);
        e[3] = pk(0, 0, 1, 0, 1, 0);
        e[4] = pk(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: cycle(1, 3, 0, 0);
                1: cycle(1, 1, 0, 0);
                default: cycle(0, 0, 1, 0);
            endcase
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL push_pop step %0d got=%b exp=%b", i, obs, e[i]);
            end
        end
        cycle(1, 2, 1, 0);
        vecs++;
        if (obs !== pk(1, 0, 0, 1, 2, 0)) begin
            errs++;
            $display("FAIL push_pop_empty got=%b exp=%b", obs, pk(1, 0, 0, 1, 2, 0));
        end
    endtask

    task automatic test_overflow();
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, i, 0, 0);
        vecs++;
        if (obs !== pk(4, 1, 0, 1, 0, 0)) begin
            errs++;
            $display("FAIL fill got=%b exp=%b", obs, pk(4, 1, 0, 1, 0, 0));
        end
        cycle(1, 2, 0, 0);
        vecs++;
        if (obs !== pk(4, 1, 0, 1, 0, !DUP)) begin
            errs++;
            $display("FAIL overflow got=%b exp=%b", obs, pk(4, 1, 0, 1, 0, !DUP));
        end
        cycle(0, 0, 1, 0);
        vecs++;
        if (obs !== pk(3, 0, 0, 1, 1, !DUP)) begin
            errs++;
            $display("FAIL overflow_sticky got=%b exp=%b", obs, pk(3, 0, 0, 1, 1, !DUP));
        end
    endtask

    task automatic test_full_swap();
        logic [OW-1:0] e [4];
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, i, 0, 0);
        e[0] = DUP ? pk(3, 0, 0, 1, 1, 0) : pk(4, 1, 0, 1, 1, 0);
        e[1] = DUP ? pk(2, 0, 0, 1, 2, 0) : pk(3, 0, 0, 1, 2, 0);
        e[2] = DUP ? pk(1, 0, 0, 1, 3, 0) : pk(2, 0, 0, 1, 3, 0);
        e[3] = DUP ? pk(0, 0, 1, 0, 3, 0) : pk(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cycle(1, 1, 1, 0);
            else cycle(0, 0, 1, 0);
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL full_swap step %0d got=%b exp=%b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_dup();
        cycle(0, 0, 0, 1);
        cycle(1, 2, 0, 0);
        cycle(1, 2, 0, 0);
        vecs++;
        if (obs !== pk(DUP ? 1 : 2, 0, 0, 1, 2, 0)) begin
            errs++;
            $display("FAIL dup_push got=%b exp=%b", obs, pk(DUP ? 1 : 2, 0, 0, 1, 2, 0));
        end
        cycle(1, 2, 1, 0);
        vecs++;
        if (obs !== pk(DUP ? 0 : 2, 0, DUP, !DUP, 2, 0)) begin
            errs++;
            $display("FAIL dup_head_served got=%b exp=%b", obs, pk(DUP ? 0 : 2, 0, DUP, !DUP, 2, 0));
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, i % 4, 0, 0);
        cycle(0, 0, 1, 0);
        vecs++;
        if (obs !== pk(3, 0, 0, 1, 1, !DUP)) begin
            errs++;
            $display("FAIL pre_reset got=%b exp=%b", obs, pk(3, 0, 0, 1, 1, !DUP));
        end
        cycle(1, 2, 1, 1);
        vecs++;
        if (obs !== pk(0, 0, 1, 0, 0, 0)) begin
            errs++;
            $display("FAIL reset_mid got=%b exp=%b", obs, pk(0, 0, 1, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        bit v;
        bit s;
        bit r;
        int f;
        cycle(0, 0, 0, 1);
        for (int phase = 0; phase < 3; phase++) begin
            for (int n = 0; n < 300; n++) begin
                r = ($urandom_range(0, 59) == 0);
                v = ($urandom_range(0, 2) != 0);
                s = (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                f = $urandom_range(0, (1 << FLOOR_W) - 1);
                cycle(v, f, s, r);
                vecs++;
                if (obs !== model_exp()) begin
                    errs++;
                    $display("FAIL random phase %0d cycle %0d got=%b exp=%b", phase, n, obs, model_exp());
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_push_pop();
        test_overflow();
        test_full_swap();
        test_dup();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
